fifo_sync_ring: RTL
===================

// Module: fifo_sync_ring
// PURPOSE
//  Parametrised synchronous FIFO: circular buffer with read/write pointers, replacing the fixed 16-stage shift chain.
//  Depth and width are set per instance. Provides full/empty/count status and simultaneous read+write.
//  Registered read data, valid one cycle after the read request. Used between same-clock producer/consumer stages.
// PARAMETERS
//  FIFO_WIDTH  8   data width in bits
//  ADDR_W      4   pointer width; DEPTH = 2**ADDR_W entries (default 16)
//  AFULL_TH    12  almost_full asserts when count >= AFULL_TH (FIFO_SYNC_ALMOST_EN only)
//  AEMPTY_TH   2   almost_empty asserts when count <= AEMPTY_TH (FIFO_SYNC_ALMOST_EN only)
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous reset, active low
//  wr_en         in   1           write request
//  wr_data       in   FIFO_WIDTH  write data
//  rd_en         in   1           read request
//  rd_data       out  FIFO_WIDTH  read data, registered
//  rd_valid      out  1           rd_data updated this cycle (1-cycle pulse)
//  full          out  1           count == DEPTH
//  empty         out  1           count == 0
//  count         out  ADDR_W+1    entries stored, 0..DEPTH
//  overflow      out  1           write dropped last cycle (1-cycle pulse)
//  underflow     out  1           read rejected last cycle (1-cycle pulse)
//  almost_full   out  1           FIFO_SYNC_ALMOST_EN only
//  almost_empty  out  1           FIFO_SYNC_ALMOST_EN only
// BEHAVIOUR
//  - One clock clk; reset rst_n asynchronous, active low. All state in always @(posedge clk or negedge rst_n).
//  - Reset: wr_ptr=rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0; so empty=1, full=0.
//    Storage array not reset. Reset mid-operation discards all contents; first write after release lands in slot 0.
//  - Write accepted (wr_acc) iff wr_en && !full: mem[wr_ptr]<=wr_data, wr_ptr<=wr_ptr+1.
//  - Read accepted (rd_acc) iff rd_en && !empty: rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr<=rd_ptr+1.
//    Otherwise rd_valid<=0 and rd_data holds its previous value.
//  - Latency: data written at edge N readable by rd_en at edge N+1; rd_data/rd_valid appear after that edge.
//  - Pointers ADDR_W bits, wrap DEPTH-1 -> 0 naturally (modulo 2**ADDR_W).
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged if both or neither. full/empty combinational from count.
//  - Simultaneous, not full/not empty: both accepted, count unchanged; write and read slots differ.
//  - Full + wr_en + rd_en: read accepted, write dropped (full sampled pre-edge); overflow<=1.
//  - Empty + wr_en + rd_en: write accepted, read rejected (no fall-through); underflow<=1.
//  - overflow<=wr_en&&full; underflow<=rd_en&&empty; both cleared next cycle unless condition repeats.
// CONFIGURATION
//  - Macro FIFO_SYNC_ALMOST_EN defined: almost_full/almost_empty ports exist,
//    almost_full=(count>=AFULL_TH), almost_empty=(count<=AEMPTY_TH), combinational from count.
//  - Not defined: both ports and related logic absent; AFULL_TH/AEMPTY_TH unused. Core behaviour identical.
// TESTING (FIFO_WIDTH=8, ADDR_W=4)
//  1 Reset: hold rst_n=0 mid-traffic -> empty=1, full=0, count=0, rd_valid=0, rd_data=0 immediately (async).
//  2 Write 0x01..0x10 (16 writes) -> full=1, count=16; 17th write 0xAA -> overflow pulses 1 cycle, count stays 16;
//    16 reads return 0x01..0x10 in order, each rd_valid 1 cycle after rd_en, then empty=1.
//  3 Read while empty -> underflow pulses, rd_valid=0, rd_data unchanged, count=0.
//  4 Preload 8 entries, then 40 cycles wr_en=rd_en=1 with incrementing data -> count stays 8,
//    output sequence continuous across pointer wrap, no overflow/underflow.
//  5 Full + wr_en=rd_en=1 with 0x55 -> oldest entry out, 0x55 not stored, overflow=1, count 16->15;
//    empty + both with 0x77 -> count=1, underflow=1, next read returns 0x77.
//  6 With FIFO_SYNC_ALMOST_EN: fill 0->16 -> almost_empty=1 for count<=2, almost_full=1 from count=12 on;
//    without macro, core tests 1-5 pass unchanged.

Source files
------------

// File: rtl/fifo_sync_ring_if.sv
// Handshake bundle for fifo_sync_ring. The producer/consumer side uses the master modport and the FIFO uses the slave modport.
// almost_full/almost_empty exist only when FIFO_SYNC_ALMOST_EN is defined.
interface fifo_sync_ring_if #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned ADDR_W     = 4
) ();
    logic                  wr_en;
    logic [FIFO_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_SYNC_ALMOST_EN
    logic                  almost_full;
    logic                  almost_empty;
`endif

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef FIFO_SYNC_ALMOST_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, count, overflow, underflow
`ifdef FIFO_SYNC_ALMOST_EN
        , output almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/fifo_sync_ring.sv
// fifo_sync_ring is a parametrised synchronous FIFO built as a circular buffer. It has a registered read port.
// The optional almost_full/almost_empty flags are enabled with `define FIFO_SYNC_ALMOST_EN.
module fifo_sync_ring #(
    parameter int unsigned FIFO_WIDTH = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned AFULL_TH   = 12,
    parameter int unsigned AEMPTY_TH  = 2
) (
    input logic             clk,
    input logic             rst_n,
    fifo_sync_ring_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count_q;
    logic [FIFO_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc;
    logic                  rd_acc;

    if (AEMPTY_TH >= AFULL_TH) begin : g_bad_thresholds
        $error("fifo_sync_ring: AEMPTY_TH must be below AFULL_TH");
    end

    always_comb begin
        full_c  = (count_q == DEPTH_CNT);
        empty_c = (count_q == '0);
        wr_acc  = bus.wr_en && !full_c;
        rd_acc  = bus.rd_en && !empty_c;
    end

    // Storage carries no reset; validity is tracked only by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr_en && full_c;
            underflow_q <= bus.rd_en && empty_c;
            rd_valid_q  <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full_c;
    assign bus.empty     = empty_c;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef FIFO_SYNC_ALMOST_EN
    assign bus.almost_full  = (count_q >= (ADDR_W+1)'(AFULL_TH));
    assign bus.almost_empty = (count_q <= (ADDR_W+1)'(AEMPTY_TH));
`endif
endmodule
